// File: rtl/dncnt.sv
// dncnt: loadable down counter with a one-cycle terminal-count pulse.
// Counts from a loaded start value to 0, pulses o_tc, then either stops in
// DONE (one-shot) or reloads the last start value and keeps running
// (auto-reload). Intended as a timeout/interval timer next to upcnt.
module dncnt #(
  parameter int DNBND = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [$clog2(DNBND+1)-1:0]    i_load_val,
  input  logic                          i_en,
  input  logic                          i_auto,
  output logic [$clog2(DNBND+1)-1:0]    o_cnt,
  output logic                          o_busy,
  output logic                          o_tc,
  output logic                          o_done
);

  localparam int CW = $clog2(DNBND + 1);
  localparam logic [CW-1:0] MAXV = CW'(DNBND);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_load;
  logic          r_busy;
  logic          r_tc;
  logic          r_done;

  logic [CW-1:0] w_ld;
  logic          w_zero;

  // Clamp the start value to DNBND. When DNBND fills the whole count width
  // every representable value is legal, so the compare is left out.
  generate
    if (DNBND == (2 ** CW) - 1) begin : g_noclamp
      assign w_ld = i_load_val;
    end else begin : g_clamp
      assign w_ld = (i_load_val > MAXV) ? MAXV : i_load_val;
    end
  endgenerate

  assign w_zero = (r_cnt == '0);

  // State machine with registered outputs; o_tc defaults low so it is only
  // ever high for the single cycle following a terminal edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_load  <= '0;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_cnt   <= w_ld;
            r_load  <= w_ld;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_start) begin
            // Restart beats both decrement and terminal count.
            r_cnt  <= w_ld;
            r_load <= w_ld;
          end else if (i_en) begin
            if (!w_zero) begin
              r_cnt <= r_cnt - CW'(1);
            end else begin
              // Terminal edge: i_auto only matters here.
              r_tc <= 1'b1;
              if (i_auto) begin
                r_cnt <= r_load;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          // Sits at zero until a new start; i_en and i_auto are ignored.
          if (i_start) begin
            r_state <= ST_RUN;
            r_cnt   <= w_ld;
            r_load  <= w_ld;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = r_busy;
  assign o_tc   = r_tc;
  assign o_done = r_done;

endmodule

// File: tb/tb_dncnt.sv
// tb_dncnt: directed bench for dncnt (DNBND=15). Expected output tuples are
// queued as each cycle's stimulus is applied and compared after the edge.
`timescale 1ns/1ps
module tb_dncnt;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic       en;
  logic       auto_r;
  logic [3:0] cnt;
  logic       busy;
  logic       tc;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  int tc_seen;
  int exp_cnt;
  string tag;

  // expected tuple {cnt[3:0], busy, tc, done}
  logic [6:0] sb_q[$];

  dncnt #(.DNBND(15)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_load_val (load_val),
    .i_en       (en),
    .i_auto     (auto_r),
    .o_cnt      (cnt),
    .o_busy     (busy),
    .o_tc       (tc),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input int c, input logic b, input logic t, input logic d);
    logic [3:0] c4;
    c4 = c[3:0];
    return {c4, b, t, d};
  endfunction

  task automatic chk(input string name, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  // pop the oldest expectation and compare with the DUT outputs now
  task automatic pop_check();
    logic [6:0] e;
    logic [6:0] o;
    o = {cnt, busy, tc, done};
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard-empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, int'(o), int'(e));
    end
  endtask

  // apply current inputs for one clock, then check the result
  task automatic step(input logic [6:0] e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (tc) tc_seen++;
    pop_check();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_val = 4'd0; en = 1'b0; auto_r = 1'b0;
    tc_seen = 0;

    // 1: reset held 4 cycles with toggling inputs
    tag = "reset";
    for (int i = 0; i < 4; i++) begin
      start = i[0]; en = ~i[0]; auto_r = i[1]; load_val = 4'(i + 3);
      step(mk(0, 0, 0, 0));
    end
    rst = 1'b0; start = 1'b0; en = 1'b0; auto_r = 1'b0;
    tag = "post-reset";
    step(mk(0, 0, 0, 0));

    // 2: one-shot from 5
    tag = "oneshot";
    start = 1'b1; load_val = 4'd5; en = 1'b1; auto_r = 1'b0;
    step(mk(5, 1, 0, 0));
    start = 1'b0;
    for (int c = 4; c >= 0; c--) step(mk(c, 1, 0, 0));
    step(mk(0, 0, 1, 1));
    tag = "done-hold";
    auto_r = 1'b1;
    step(mk(0, 0, 0, 1));
    en = 1'b0;
    step(mk(0, 0, 0, 1));

    // 3: auto-reload from 15 over 50 cycles
    tag = "auto";
    start = 1'b1; load_val = 4'd15; en = 1'b1; auto_r = 1'b1;
    step(mk(15, 1, 0, 0));
    start = 1'b0;
    tc_seen = 0;
    for (int i = 1; i < 50; i++) begin
      exp_cnt = 15 - (i % 16);
      step(mk(exp_cnt, 1, (i % 16) == 0, 0));
    end
    tag = "auto-tc-count";
    chk(tag, tc_seen, 3);

    // 4: enable gating from 3, one-shot
    tag = "gating";
    auto_r = 1'b0; start = 1'b1; load_val = 4'd3; en = 1'b0;
    step(mk(3, 1, 0, 0));
    start = 1'b0;
    en = 1'b1; step(mk(2, 1, 0, 0));
    en = 1'b0; step(mk(2, 1, 0, 0));
    en = 1'b1; step(mk(1, 1, 0, 0));
    en = 1'b0; step(mk(1, 1, 0, 0));
    en = 1'b1; step(mk(0, 1, 0, 0));
    en = 1'b0; step(mk(0, 1, 0, 0));
    en = 1'b1; step(mk(0, 0, 1, 1));

    // 5: maximum load, then restart with zero -> tc on next enabled edge
    tag = "max-load";
    start = 1'b1; load_val = 4'd15; en = 1'b0;
    step(mk(15, 1, 0, 0));
    tag = "zero-load";
    load_val = 4'd0;
    step(mk(0, 1, 0, 0));
    start = 1'b0; en = 1'b1;
    step(mk(0, 0, 1, 1));

    // 6a: restart at 7 with load 2, no tc
    tag = "restart";
    start = 1'b1; load_val = 4'd9;
    step(mk(9, 1, 0, 0));
    start = 1'b0;
    step(mk(8, 1, 0, 0));
    step(mk(7, 1, 0, 0));
    start = 1'b1; load_val = 4'd2;
    step(mk(2, 1, 0, 0));
    start = 1'b0;
    step(mk(1, 1, 0, 0));
    step(mk(0, 1, 0, 0));
    step(mk(0, 0, 1, 1));

    // 6b: asynchronous reset mid-cycle at count 4
    tag = "abort-setup";
    start = 1'b1; load_val = 4'd6;
    step(mk(6, 1, 0, 0));
    start = 1'b0;
    step(mk(5, 1, 0, 0));
    step(mk(4, 1, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    tag = "async-rst";
    sb_q.push_back(mk(0, 0, 0, 0));
    pop_check();
    tag = "rst-held";
    step(mk(0, 0, 0, 0));
    rst = 1'b0;
    tag = "idle-after-rst";
    step(mk(0, 0, 0, 0));

    tag = "sb-drained";
    chk(tag, sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
